// File: rtl/cipher_pkg.sv
// Shared constants, state encoding and key reduction for the mod-227 character cipher.
package cipher_pkg;

    localparam int         P_MOD            = 227;
    localparam logic [7:0] NULL_CHAR        = 8'h00;
    localparam logic [7:0] LOWERCASE_A_CHAR = 8'h61;
    localparam logic [7:0] LOWERCASE_Z_CHAR = 8'h7A;
    localparam logic [1:0] MODE_DECRYPT     = 2'b01;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // Keys 227..255 alias 0..28, so a single subtract brings any byte into range.
    function automatic logic [7:0] reduce_key(input logic [7:0] k);
        return (k >= 8'(P_MOD)) ? k - 8'(P_MOD) : k;
    endfunction

endpackage

// File: rtl/decryption_stream_if.sv
// Stream, control and status signals of the decryption_stream block.
interface decryption_stream_if #(parameter int MAX_LEN = 32);

    localparam int CW = $clog2(MAX_LEN + 1);

    logic [1:0]    mode;
    logic          start;
    logic [7:0]    Public_key;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    Char_ciphertext;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    Char_plaintext;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] char_count;
    logic          err_invalid_ctxt;
    logic          err_invalid_ptxt;
    logic          err_overflow;

    modport master (
        output mode, start, Public_key, in_valid, Char_ciphertext, out_ready,
        input  in_ready, out_valid, Char_plaintext, out_last, busy, char_count,
               err_invalid_ctxt, err_invalid_ptxt, err_overflow
    );

    modport slave (
        input  mode, start, Public_key, in_valid, Char_ciphertext, out_ready,
        output in_ready, out_valid, Char_plaintext, out_last, busy, char_count,
               err_invalid_ctxt, err_invalid_ptxt, err_overflow
    );

endinterface

// File: rtl/mod_add_p227.sv
// Combinational P = (C + K') mod 227 with ciphertext and lowercase-plaintext validity flags.
module mod_add_p227
    import cipher_pkg::*;
(
    input  logic [7:0] c_i,
    input  logic [7:0] k_i,
    output logic [7:0] p_o,
    output logic       ctxt_ok_o,
    output logic       ptxt_ok_o
);

    logic [8:0] sum;

    // With C and K' both below 227 the sum never exceeds 452, so one subtract suffices.
    assign sum       = {1'b0, c_i} + {1'b0, k_i};
    assign p_o       = (sum >= 9'(P_MOD)) ? 8'(sum - 9'(P_MOD)) : sum[7:0];
    assign ctxt_ok_o = (c_i < 8'(P_MOD));
    assign ptxt_ok_o = (p_o >= LOWERCASE_A_CHAR) && (p_o <= LOWERCASE_Z_CHAR);

endmodule

// File: rtl/decryption_stream.sv
// Receive side of the mod-227 cipher: one message per start pulse, registered output stage.
//
//   state | meaning
//   IDLE  | no message open, ciphertext refused
//   RUN   | message open, accepting ciphertext
//   DRAIN | final byte held in output register until taken
module decryption_stream
    import cipher_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    decryption_stream_if.slave  bus
);

    localparam int              CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_LEN - 1);

    state_t        state_q, state_d;
    logic [7:0]    key_q, key_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_ctxt_q, err_ctxt_d;
    logic          err_ptxt_q, err_ptxt_d;
    logic          err_ovf_q, err_ovf_d;

    logic [7:0]    ptxt;
    logic          ctxt_ok;
    logic          ptxt_ok;
    logic          mode_ok;
    logic          in_ready;
    logic          accept;
    logic          consume;

    mod_add_p227 u_mod_add (
        .c_i       (bus.Char_ciphertext),
        .k_i       (key_q),
        .p_o       (ptxt),
        .ctxt_ok_o (ctxt_ok),
        .ptxt_ok_o (ptxt_ok)
    );

    assign mode_ok  = (bus.mode == MODE_DECRYPT);
    assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;
        err_ctxt_d  = err_ctxt_q;
        err_ptxt_d  = err_ptxt_q;
        err_ovf_d   = err_ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start && mode_ok) begin
                    key_d      = reduce_key(bus.Public_key);
                    cnt_d      = '0;
                    err_ctxt_d = 1'b0;
                    err_ptxt_d = 1'b0;
                    err_ovf_d  = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN, DRAIN: begin
                // Abort wins over any same-cycle handshake; flags stay for inspection.
                if (!mode_ok) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    if (bus.Char_ciphertext == NULL_CHAR) begin
                        out_data_d = NULL_CHAR;
                        out_last_d = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!ctxt_ok) begin
                            out_data_d = NULL_CHAR;
                            err_ctxt_d = 1'b1;
                        end else if (!ptxt_ok) begin
                            out_data_d = NULL_CHAR;
                            err_ptxt_d = 1'b1;
                        end else begin
                            out_data_d = ptxt;
                        end
                        if (cnt_q == CNT_LAST) begin
                            out_last_d = 1'b1;
                            err_ovf_d  = 1'b1;
                            state_d    = DRAIN;
                        end
                    end
                end else if (consume) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (state_q == DRAIN) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= NULL_CHAR;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
            err_ctxt_q  <= 1'b0;
            err_ptxt_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
            err_ctxt_q  <= err_ctxt_d;
            err_ptxt_q  <= err_ptxt_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid_q;
    assign bus.Char_plaintext   = out_data_q;
    assign bus.out_last         = out_last_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.char_count       = cnt_q;
    assign bus.err_invalid_ctxt = err_ctxt_q;
    assign bus.err_invalid_ptxt = err_ptxt_q;
    assign bus.err_overflow     = err_ovf_q;

endmodule

// File: tb/tb_decryption_stream.sv
// Directed bench for decryption_stream with a message-level reference model and per-cycle compare.
module tb_decryption_stream;

    localparam int MAX_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decryption_stream_if #(.MAX_LEN(MAX_LEN)) bus ();

    decryption_stream #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: 0 = no message, 1 = message open, 2 = waiting for final byte to leave.
    int   m_phase = 0;
    bit   m_ov = 0, m_last = 0;
    int   m_data = 0, m_key = 0, m_cnt = 0;
    bit   m_ectx = 0, m_eptx = 0, m_eovf = 0;
    bit   m_acc;
    int   m_p;

    always @(posedge clk) begin
        m_acc = (m_phase == 1) && bus.in_valid && (!m_ov || bus.out_ready);
        if (rst) begin
            m_phase = 0; m_ov = 0; m_last = 0; m_data = 0; m_key = 0; m_cnt = 0;
            m_ectx = 0; m_eptx = 0; m_eovf = 0;
        end else if (m_phase != 0 && bus.mode != 2'b01) begin
            m_phase = 0; m_ov = 0; m_last = 0;
        end else if (m_phase == 0) begin
            if (bus.start && bus.mode == 2'b01) begin
                m_key = int'(bus.Public_key) % 227;
                m_cnt = 0; m_ectx = 0; m_eptx = 0; m_eovf = 0;
                m_phase = 1;
            end
        end else if (m_acc) begin
            m_ov = 1;
            if (bus.Char_ciphertext == 8'h00) begin
                m_data = 0; m_last = 1; m_phase = 2;
            end else begin
                m_cnt++;
                if (bus.Char_ciphertext >= 227) begin
                    m_data = 0; m_ectx = 1;
                end else begin
                    m_p = (int'(bus.Char_ciphertext) + m_key) % 227;
                    if (m_p >= 97 && m_p <= 122) m_data = m_p;
                    else begin m_data = 0; m_eptx = 1; end
                end
                m_last = 0;
                if (m_cnt == MAX_LEN) begin
                    m_last = 1; m_eovf = 1; m_phase = 2;
                end
            end
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0; m_last = 0;
            if (m_phase == 2) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, 32'((m_phase == 1) && (!m_ov || bus.out_ready)));
            chk("out_valid", bus.out_valid, m_ov);
            chk("busy", bus.busy, 32'(m_phase != 0));
            chk("char_count", bus.char_count, m_cnt);
            chk("err_invalid_ctxt", bus.err_invalid_ctxt, m_ectx);
            chk("err_invalid_ptxt", bus.err_invalid_ptxt, m_eptx);
            chk("err_overflow", bus.err_overflow, m_eovf);
            if (m_ov) begin
                chk("Char_plaintext", bus.Char_plaintext, m_data);
                chk("out_last", bus.out_last, m_last);
            end
        end
    end

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.Char_plaintext});
    end

    task automatic ex(input logic l, input logic [7:0] d);
        exp_q.push_back({l, d});
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic open_msg(input logic [7:0] k);
        bus.mode       = 2'b01;
        bus.Public_key = k;
        bus.start      = 1'b1;
        tick(1);
        bus.start      = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, output int stalls);
        bus.Char_ciphertext = c;
        bus.in_valid        = 1'b1;
        stalls              = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            stalls++;
            if (stalls > 40) begin
                chk("send_timeout", stalls, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] c);
        int s;
        send(c, s);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.busy || n >= 20) break;
            n++;
        end
        chk("wait_idle", bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, s1, s2, s3;
        bus.mode = 2'b00; bus.start = 1'b0; bus.Public_key = 8'h00;
        bus.in_valid = 1'b0; bus.Char_ciphertext = 8'h00; bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick(1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ptxt", bus.Char_plaintext, 8'h00);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        tick(1);

        // K=3 basic message
        open_msg(8'd3);
        send_s(8'h5E); send_s(8'h5F); send_s(8'h00);
        wait_idle();
        ex(0, 8'h61); ex(0, 8'h62); ex(1, 8'h00);
        check_seq("k3");
        chk("k3_count", bus.char_count, 2);
        chk("k3_ectx", bus.err_invalid_ctxt, 0);
        chk("k3_eptx", bus.err_invalid_ptxt, 0);
        chk("k3_eovf", bus.err_overflow, 0);

        // Wrap-around with K=200
        open_msg(8'hC8);
        send_s(8'h7C); send_s(8'h95); send_s(8'h00);
        wait_idle();
        ex(0, 8'h61); ex(0, 8'h7A); ex(1, 8'h00);
        check_seq("wrap");

        // K=230 reduces to 3; a start pulse mid-message must not reload the key
        open_msg(8'd230);
        send_s(8'h5E);
        bus.Public_key = 8'h00; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        send_s(8'h5F); send_s(8'h00);
        wait_idle();
        ex(0, 8'h61); ex(0, 8'h62); ex(1, 8'h00);
        check_seq("keyred");
        chk("keyred_count", bus.char_count, 2);

        // Invalid ciphertext and invalid plaintext, flags sticky until next start
        open_msg(8'd3);
        send_s(8'hE5); send_s(8'h10); send_s(8'h00);
        wait_idle();
        ex(0, 8'h00); ex(0, 8'h00); ex(1, 8'h00);
        check_seq("invalid");
        chk("inv_ectx", bus.err_invalid_ctxt, 1);
        chk("inv_eptx", bus.err_invalid_ptxt, 1);
        tick(3);
        chk("inv_ectx_held", bus.err_invalid_ctxt, 1);
        chk("inv_eptx_held", bus.err_invalid_ptxt, 1);
        open_msg(8'd3);
        chk("inv_ectx_clr", bus.err_invalid_ctxt, 0);
        chk("inv_eptx_clr", bus.err_invalid_ptxt, 0);
        send_s(8'h00);
        wait_idle();
        ex(1, 8'h00);
        check_seq("empty");
        chk("empty_count", bus.char_count, 0);

        // Backpressure for 3 cycles, then full-rate streaming
        open_msg(8'd3);
        bus.out_ready = 1'b0;
        send(8'h5E, s0);
        chk("bp_first_stalls", s0, 0);
        fork
            send(8'h5F, s1);
            begin
                for (int i = 0; i < 3; i++) begin
                    tick(1);
                    chk("bp_hold_valid", bus.out_valid, 1);
                    chk("bp_hold_data", bus.Char_plaintext, 8'h61);
                end
                bus.out_ready = 1'b1;
            end
        join
        chk("bp_stalls", s1, 3);
        send(8'h60, s2);
        send(8'h00, s3);
        chk("bp_thru_stalls", s2 + s3, 0);
        wait_idle();
        ex(0, 8'h61); ex(0, 8'h62); ex(0, 8'h63); ex(1, 8'h00);
        check_seq("bp");

        // Overflow at MAX_LEN=4 without terminator
        open_msg(8'd3);
        send_s(8'h5E); send_s(8'h5F); send_s(8'h60); send_s(8'h61);
        chk("ovf_flag", bus.err_overflow, 1);
        chk("ovf_count", bus.char_count, 4);
        chk("ovf_last", bus.out_last, 1);
        bus.Char_ciphertext = 8'h62; bus.in_valid = 1'b1;
        tick(3);
        bus.in_valid = 1'b0;
        wait_idle();
        ex(0, 8'h61); ex(0, 8'h62); ex(0, 8'h63); ex(1, 8'h64);
        check_seq("ovf");
        chk("ovf_held", bus.err_overflow, 1);

        // Reset mid-message drops the pending byte
        open_msg(8'd3);
        bus.out_ready = 1'b0;
        send_s(8'h5E);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstm_out_valid", bus.out_valid, 0);
        chk("rstm_busy", bus.busy, 0);
        chk("rstm_in_ready", bus.in_ready, 0);
        chk("rstm_count", bus.char_count, 0);
        chk("rstm_ptxt", bus.Char_plaintext, 8'h00);
        check_seq("rstm");
        bus.out_ready = 1'b1;
        tick(1);

        // Mode change mid-message aborts; error flags survive
        open_msg(8'd3);
        send_s(8'h10);
        tick(1);
        bus.out_ready = 1'b0;
        send_s(8'h5E);
        bus.mode = 2'b10;
        tick(1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_eptx", bus.err_invalid_ptxt, 1);
        chk("abort_count", bus.char_count, 2);
        ex(0, 8'h00);
        check_seq("abort");

        // start is ignored while mode is not decrypt
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("nomode_busy", bus.busy, 0);
        bus.mode = 2'b01;
        bus.out_ready = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
